// File: rtl/forth_useq_decoder.sv
// forth_useq_decoder: FETCH/EXEC micro-sequencer for the 3-bit Forth core with memory wait-states, timeout and halt.
// Optional retire counter enabled by defining DECODER_RETIRE_CNT_EN.
module forth_useq_decoder #(
  parameter int XW       = 3,
  parameter int NJ       = 4,
  parameter int JFW      = (1 + $clog2(NJ)) > 3 ? 1 + $clog2(NJ) : 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       Data_Out,
  input  logic [XW-1:0]    RegT,
  input  logic             regF,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [1:0]       A_Sel,
  output logic             B_Sel,
  output logic             C_Sel,
  output logic             D_Sel,
  output logic             R_F,
  output logic             H_F,
  output logic             T_F,
  output logic [1:0]       ALU_F,
  output logic [1:0]       I_F,
  output logic [1:0]       S_F,
  output logic [1:0]       F_F,
  output logic [JFW-1:0]   J_F,
  output logic             phase,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int LB = $clog2(NJ);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {FETCH, EXEC, WAIT, HALT} state_t;
  typedef struct packed {
    logic [1:0]     a;
    logic           b, c, d, r;
    logic [1:0]     f, i;
    logic [JFW-1:0] j;
    logic [1:0]     s;
    logic           h, t;
    logic [1:0]     alu;
  } cw_t;
  localparam cw_t IDLE = '{a: 2'd0, b: 1'b0, c: 1'b0, d: 1'b0, r: 1'b0, f: 2'd0, i: 2'd0,
                           j: '0, s: 2'd0, h: 1'b0, t: 1'b0, alu: 2'b10};
  function automatic cw_t decode(input logic [2:0] op, input logic [XW-1:0] x, input logic fl);
    cw_t w;
    w = IDLE;
    case (op)
      3'd0: begin w.i = 2'b01; w.t = 1'b1; w.alu = 2'b00; end
      3'd1: begin w.a = 2'b01; w.r = 1'b1; w.i = 2'b01; w.j = JFW'(1); end
      3'd2: begin w.a = 2'b01; w.i = 2'b01; w.j = JFW'(1); w.t = 1'b1; end
      3'd3: begin
        w.i = 2'b01;
        w.t = 1'b1;
        if (x[XW-1]) begin
          // Bank swap: J index is the bank number with the top bit set (NJ is a power of 2)
          w.a = 2'b10; w.b = 1'b1; w.c = 1'b1; w.f = 2'b01; w.s = 2'b01;
          w.j = JFW'(NJ) | JFW'(x[LB-1:0]);
        end else if (x[0]) begin
          w.a = 2'b01; w.s = 2'b11;
        end else begin
          w.a = 2'b10; w.j = JFW'(2);
        end
      end
      3'd4: begin w.a = 2'b10; w.r = 1'b1; w.i = 2'b01; w.s = 2'b10; end
      3'd5: begin w.a = 2'b10; w.f = 2'b01; w.i = 2'b01; w.s = 2'b01; w.t = 1'b1; w.alu = 2'b11; end
      3'd6: begin w.f = 2'b11; w.j = JFW'(2); w.i = fl ? 2'b10 : 2'b01; end
      default: begin w.i = 2'b01; w.t = 1'b1; w.alu = 2'b01; end
    endcase
    return w;
  endfunction
  state_t        state;
  cw_t           cw, dw, hw;
  logic [2:0]    q_op, s_op;
  logic [XW-1:0] q_x, s_x;
  logic          q_f, s_f, is_mem;
  logic [WW-1:0] wait_cnt;
  always_comb begin
    s_op   = state == WAIT ? q_op : Data_Out;
    s_x    = state == WAIT ? q_x : RegT;
    s_f    = state == WAIT ? q_f : regF;
    dw     = decode(s_op, s_x, s_f);
    is_mem = s_op == 3'd1 || s_op == 3'd2 || s_op == 3'd4 || s_op == 3'd5 || (s_op == 3'd3 && s_x[XW-1]);
    hw     = dw;
    hw.i   = 2'd0;
    hw.j   = '0;
    hw.s   = 2'd0;
    hw.f   = 2'd0;
    hw.t   = 1'b0;
    hw.h   = 1'b0;
  end
`ifdef DECODER_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if ((state == EXEC && (!is_mem || mem_ready)) || (state == WAIT && mem_ready)) cnt <= cnt + CNT_W'(1);
  assign retire_cnt = cnt;
`else
  assign retire_cnt = '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      cw       <= IDLE;
      phase    <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      q_op     <= '0;
      q_x      <= '0;
      q_f      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          cw     <= IDLE;
          phase  <= 1'b0;
          halted <= 1'b0;
          state  <= halt_req ? HALT : EXEC;
        end
        EXEC: begin
          phase  <= 1'b1;
          halted <= 1'b0;
          if (!is_mem || mem_ready) begin
            cw    <= dw;
            state <= FETCH;
          end else begin
            cw       <= hw;
            q_op     <= Data_Out;
            q_x      <= RegT;
            q_f      <= regF;
            wait_cnt <= WW'(1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          halted <= 1'b0;
          if (mem_ready) begin
            cw    <= dw;
            phase <= 1'b1;
            state <= FETCH;
          end else if (wait_cnt == WW'(WAIT_MAX)) begin
            cw    <= IDLE;
            phase <= 1'b0;
            err   <= 1'b1;
            state <= HALT;
          end else begin
            cw       <= hw;
            phase    <= 1'b1;
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: begin
          cw     <= IDLE;
          phase  <= 1'b0;
          halted <= 1'b1;
          state  <= !halt_req && !err ? FETCH : HALT;
        end
      endcase
    end
  end
  assign A_Sel = cw.a;
  assign B_Sel = cw.b;
  assign C_Sel = cw.c;
  assign D_Sel = cw.d;
  assign R_F   = cw.r;
  assign F_F   = cw.f;
  assign I_F   = cw.i;
  assign J_F   = cw.j;
  assign S_F   = cw.s;
  assign H_F   = cw.h;
  assign T_F   = cw.t;
  assign ALU_F = cw.alu;
endmodule
